// File: rtl/gem_pkg.sv
// Shared types and constants for the gem spawner slice.
package gem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    FETCH = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } spawn_state_t;

  typedef struct packed {
    shortint x;
    shortint y;
  } gem_pos_t;

  localparam int DEF_SPAWN_GAP     = 30;
  localparam int DEF_RESPAWN_DELAY = 120;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsrNext(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/gem_spawner_if.sv
// Gem bus between the spawner (master) and level logic, table ROM and slot sinks.
interface gem_spawner_if #(
  parameter int SLOTS      = 4,
  parameter int TOTAL_GEMS = 8
);
  localparam int AW = $clog2(TOTAL_GEMS);
  localparam int SW = $clog2(TOTAL_GEMS + 1);

  logic                  frame_tick;
  logic                  level_start;
  logic [SLOTS-1:0]      collect;
  logic [AW-1:0]         tbl_addr;
  logic [15:0]           tbl_x;
  logic [15:0]           tbl_y;
  logic [SLOTS*16-1:0]   slot_x;
  logic [SLOTS*16-1:0]   slot_y;
  logic [SLOTS-1:0]      slot_active;
  logic [SW-1:0]         score;
  logic                  all_collected;

  modport master (
    input  frame_tick, level_start, collect, tbl_x, tbl_y,
    output tbl_addr, slot_x, slot_y, slot_active, score, all_collected
  );

  modport slave (
    output frame_tick, level_start, collect, tbl_x, tbl_y,
    input  tbl_addr, slot_x, slot_y, slot_active, score, all_collected
  );

endinterface

// File: rtl/gem_slot_timer.sv
// Per-slot respawn bookkeeping: a pending flag plus a frame countdown that stops at zero.
module gem_slot_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               frame_tick_i,
  input  logic               clear_i,
  output logic               ready_o
);

  logic               pending_q, pending_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  // Load wins over clear so a level restart always re-arms every slot
  always_comb begin
    pending_d = pending_q;
    timer_d   = timer_q;
    if (load_i) begin
      pending_d = 1'b1;
      timer_d   = load_val_i;
    end else if (clear_i) begin
      pending_d = 1'b0;
    end else if (frame_tick_i && pending_q && (timer_q != '0)) begin
      timer_d = timer_q - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      pending_q <= pending_d;
      timer_q   <= timer_d;
    end
  end

  assign ready_o = pending_q && (timer_q == '0);

endmodule

// File: rtl/gem_spawner.sv
// Gem slot spawner: places gems from the level table, retires collected ones, keeps score.
// Optional respawn jitter from an 8-bit LFSR: define GEM_SPAWN_JITTER_EN.
module gem_spawner
  import gem_pkg::*;
#(
  parameter int SLOTS         = 4,
  parameter int TOTAL_GEMS    = 8,
  parameter int SPAWN_GAP     = DEF_SPAWN_GAP,
  parameter int RESPAWN_DELAY = DEF_RESPAWN_DELAY,
  parameter int TIMER_W       = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  gem_spawner_if.master bus
);

  localparam int AW   = $clog2(TOTAL_GEMS);
  localparam int SW   = $clog2(TOTAL_GEMS + 1);
  localparam int SELW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  spawn_state_t        state_q, state_d;
  logic [SELW-1:0]     sel_q, sel_d;
  logic [AW-1:0]       tblAddr_q, tblAddr_d;
  logic [SW-1:0]       nextIdx_q, nextIdx_d;
  logic [SW-1:0]       score_q, score_d;
  logic [SLOTS-1:0]    slotActive_q, slotActive_d;
  logic [SLOTS*16-1:0] slotX_q, slotX_d;
  logic [SLOTS*16-1:0] slotY_q, slotY_d;

  logic                          running;
  logic                          haveGems;
  logic [SLOTS-1:0]              writeMask;
  logic [SLOTS-1:0]              counted;
  logic [SLOTS-1:0]              slotReady;
  logic [SLOTS-1:0]              timerLoad;
  logic [SLOTS-1:0]              timerClear;
  logic [SLOTS-1:0][TIMER_W-1:0] timerVal;
  logic [TIMER_W-1:0]            respawnVal;
  logic                          readyFound;
  logic [SELW-1:0]               readyIdx;
  logic [SW:0]                   scoreSum;
  logic [SW-1:0]                 scoreSat;
  gem_pos_t                      fetched;

  assign running   = (state_q == SCAN) || (state_q == FETCH) || (state_q == WRITE);
  assign haveGems  = (int'(nextIdx_q) < TOTAL_GEMS);
  assign writeMask = (state_q == WRITE) ? (SLOTS'(1) << sel_q) : '0;
  assign counted   = running ? (bus.collect & slotActive_q & ~writeMask) : '0;
  assign scoreSum  = {1'b0, score_q} + (SW+1)'($countones(counted));
  assign scoreSat  = (int'(scoreSum) > TOTAL_GEMS) ? SW'(TOTAL_GEMS) : scoreSum[SW-1:0];
  assign fetched   = '{x: shortint'(bus.tbl_x), y: shortint'(bus.tbl_y)};

`ifdef GEM_SPAWN_JITTER_EN
  logic [7:0] lfsr_q;

  // Free-running per frame so the jitter differs between successive collections
  always_ff @(posedge Clk) begin
    if (Reset || bus.level_start) begin
      lfsr_q <= LFSR_SEED;
    end else if (bus.frame_tick) begin
      lfsr_q <= lfsrNext(lfsr_q);
    end
  end

  assign respawnVal = TIMER_W'(RESPAWN_DELAY) + TIMER_W'(lfsr_q[4:0]);
`else
  assign respawnVal = TIMER_W'(RESPAWN_DELAY);
`endif

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      timerLoad[i]  = bus.level_start || (counted[i] && haveGems);
      timerVal[i]   = bus.level_start ? TIMER_W'(SPAWN_GAP * (i + 1)) : respawnVal;
      timerClear[i] = (state_q == WRITE) && (int'(sel_q) == i);
    end
  end

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    gem_slot_timer #(.TIMER_W(TIMER_W)) u_timer (
      .Clk          (Clk),
      .Reset        (Reset),
      .load_i       (timerLoad[i]),
      .load_val_i   (timerVal[i]),
      .frame_tick_i (bus.frame_tick && running),
      .clear_i      (timerClear[i]),
      .ready_o      (slotReady[i])
    );
  end

  // Lowest-index ready slot wins; the rest keep waiting at zero
  always_comb begin
    readyFound = 1'b0;
    readyIdx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (slotReady[i] && haveGems) begin
        readyFound = 1'b1;
        readyIdx   = SELW'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    tblAddr_d    = tblAddr_q;
    nextIdx_d    = nextIdx_q;
    score_d      = score_q;
    slotActive_d = slotActive_q;
    slotX_d      = slotX_q;
    slotY_d      = slotY_q;
    if (bus.level_start) begin
      state_d      = SCAN;
      slotActive_d = '0;
      score_d      = '0;
      nextIdx_d    = '0;
    end else begin
      case (state_q)
        SCAN: begin
          if (readyFound) begin
            sel_d     = readyIdx;
            tblAddr_d = nextIdx_q[AW-1:0];
            state_d   = FETCH;
          end
        end
        FETCH: state_d = WRITE;
        WRITE: begin
          slotX_d[int'(sel_q)*16 +: 16] = fetched.x;
          slotY_d[int'(sel_q)*16 +: 16] = fetched.y;
          slotActive_d[sel_q]           = 1'b1;
          nextIdx_d                     = nextIdx_q + SW'(1);
          state_d                       = SCAN;
        end
        IDLE, DONE: ;
        default: state_d = IDLE;
      endcase
      // Collections overlay whatever the placement step did this cycle
      if (running) begin
        slotActive_d = slotActive_d & ~counted;
        score_d      = scoreSat;
        if (int'(scoreSat) == TOTAL_GEMS) begin
          state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      tblAddr_q    <= '0;
      nextIdx_q    <= '0;
      score_q      <= '0;
      slotActive_q <= '0;
      slotX_q      <= '0;
      slotY_q      <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      tblAddr_q    <= tblAddr_d;
      nextIdx_q    <= nextIdx_d;
      score_q      <= score_d;
      slotActive_q <= slotActive_d;
      slotX_q      <= slotX_d;
      slotY_q      <= slotY_d;
    end
  end

  assign bus.tbl_addr      = tblAddr_q;
  assign bus.slot_x        = slotX_q;
  assign bus.slot_y        = slotY_q;
  assign bus.slot_active   = slotActive_q;
  assign bus.score         = score_q;
  assign bus.all_collected = (int'(score_q) == TOTAL_GEMS);

endmodule

// File: tb/tb_gem_spawner.sv
// Directed bench for gem_spawner: spawn staggering, collection, respawn, exhaustion, restart.
module tb_gem_spawner;
  import gem_pkg::*;

  localparam int SLOTS = 4;
  localparam int TOTAL = 8;

  typedef struct {
    logic [3:0] col;
    int         hold;
    logic [3:0] expActive;
    int         expScore;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] romX [TOTAL];
  logic [15:0] romY [TOTAL];
  logic [3:0]  expAct;
  int          respawnR;
  vec_t        vecs [5];

`ifdef GEM_SPAWN_JITTER_EN
  logic [7:0] tbLfsr;
`endif

  always #5 Clk = ~Clk;

  gem_spawner_if #(.SLOTS(SLOTS), .TOTAL_GEMS(TOTAL)) bus ();

  gem_spawner #(
    .SLOTS(SLOTS), .TOTAL_GEMS(TOTAL), .SPAWN_GAP(30), .RESPAWN_DELAY(120), .TIMER_W(8)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Synchronous position ROM with one cycle of latency
  always @(posedge Clk) begin
    bus.tbl_x <= romX[bus.tbl_addr];
    bus.tbl_y <= romY[bus.tbl_addr];
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic ft, input logic ls, input logic [3:0] col, input int n);
    bus.frame_tick  = ft;
    bus.level_start = ls;
    bus.collect     = col;
    repeat (n) begin
      step(1);
`ifdef GEM_SPAWN_JITTER_EN
      if (ls) tbLfsr = 8'hA5;
      else if (ft) tbLfsr = {tbLfsr[6:0], tbLfsr[7] ^ tbLfsr[5] ^ tbLfsr[4] ^ tbLfsr[3]};
`endif
    end
    bus.frame_tick  = 1'b0;
    bus.level_start = 1'b0;
    bus.collect     = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 4'b0000, 1);
  endtask

  function automatic int respawnDelay();
`ifdef GEM_SPAWN_JITTER_EN
    return 120 + int'(tbLfsr[4:0]);
`else
    return 120;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkSlot(input string name, input int s, input int idx);
    checkOutput({name, "_x"}, 32'(bus.slot_x[s*16 +: 16]), 32'(romX[idx]));
    checkOutput({name, "_y"}, 32'(bus.slot_y[s*16 +: 16]), 32'(romY[idx]));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < TOTAL; i++) begin
      romX[i] = 16'(320 + 17 * i);
      romY[i] = 16'(440 - 23 * i);
    end
    vecs[0] = '{4'b0101, 1,  4'b1010, 2};
    vecs[1] = '{4'b0010, 10, 4'b1000, 3};
    vecs[2] = '{4'b0000, 1,  4'b1000, 3};
    vecs[3] = '{4'b0101, 1,  4'b1000, 3};
    vecs[4] = '{4'b1000, 1,  4'b0000, 4};

    Reset = 1'b1;
    bus.frame_tick = 1'b0;
    bus.level_start = 1'b0;
    bus.collect = '0;
`ifdef GEM_SPAWN_JITTER_EN
    tbLfsr = 8'hA5;
`endif
    step(3);
    Reset = 1'b0;
    step(1);
    checkOutput("resetActive", 32'(bus.slot_active), 32'h0);
    checkOutput("resetScore", 32'(bus.score), 32'h0);
    checkOutput("resetAll", 32'(bus.all_collected), 32'h0);
    checkOutput("resetAddr", 32'(bus.tbl_addr), 32'h0);
    checkOutput("resetPosZero", 32'(bus.slot_x == '0 && bus.slot_y == '0), 32'h1);
    checkOutput("resetState", 32'(dut.state_q), 32'(IDLE));

    tick(40);
    checkOutput("idleTicksActive", 32'(bus.slot_active), 32'h0);
    checkOutput("idleTicksState", 32'(dut.state_q), 32'(IDLE));

    applyStimulus(1'b0, 1'b1, 4'b0000, 1);
    checkOutput("startState", 32'(dut.state_q), 32'(SCAN));

    // Staggered initial spawns: one slot per 30 frames, visible 3 cycles after the expiring tick
    expAct = 4'b0000;
    for (int s = 0; s < SLOTS; s++) begin
      tick(29);
      step(4);
      checkOutput($sformatf("preSpawn%0d", s), 32'(bus.slot_active), 32'(expAct));
      tick(1);
      step(2);
      checkOutput($sformatf("latency%0d", s), 32'(bus.slot_active), 32'(expAct));
      step(1);
      expAct[s] = 1'b1;
      checkOutput($sformatf("spawn%0d", s), 32'(bus.slot_active), 32'(expAct));
      checkOutput($sformatf("spawnAddr%0d", s), 32'(bus.tbl_addr), 32'(s));
      checkSlot($sformatf("spawnPos%0d", s), s, s);
    end

    for (int v = 0; v < 5; v++) begin
      applyStimulus(1'b0, 1'b0, vecs[v].col, vecs[v].hold);
      checkOutput($sformatf("vecActive%0d", v), 32'(bus.slot_active), 32'(vecs[v].expActive));
      checkOutput($sformatf("vecScore%0d", v), 32'(bus.score), 32'(vecs[v].expScore));
    end

    // All four slots expire together; refills come lowest index first, 3 cycles apart
    respawnR = respawnDelay();
    tick(respawnR - 1);
    step(4);
    checkOutput("preRespawn", 32'(bus.slot_active), 32'h0);
    tick(1);
    step(2);
    checkOutput("respawnLatency", 32'(bus.slot_active), 32'h0);
    expAct = 4'b0000;
    for (int s = 0; s < SLOTS; s++) begin
      step((s == 0) ? 1 : 3);
      expAct[s] = 1'b1;
      checkOutput($sformatf("respawn%0d", s), 32'(bus.slot_active), 32'(expAct));
      checkSlot($sformatf("respawnPos%0d", s), s, 4 + s);
    end

    applyStimulus(1'b0, 1'b0, 4'b0111, 1);
    checkOutput("exhaustScore", 32'(bus.score), 32'd7);
    checkOutput("exhaustAll", 32'(bus.all_collected), 32'h0);
    tick(200);
    step(5);
    checkOutput("exhaustEmpty", 32'(bus.slot_active), 32'b1000);
    checkOutput("exhaustState", 32'(dut.state_q), 32'(SCAN));

    applyStimulus(1'b0, 1'b0, 4'b1000, 1);
    checkOutput("doneScore", 32'(bus.score), 32'd8);
    checkOutput("doneAll", 32'(bus.all_collected), 32'h1);
    checkOutput("doneActive", 32'(bus.slot_active), 32'h0);
    checkOutput("doneState", 32'(dut.state_q), 32'(DONE));
    tick(10);
    applyStimulus(1'b0, 1'b0, 4'b1111, 3);
    checkOutput("doneHoldScore", 32'(bus.score), 32'd8);
    checkOutput("doneHoldActive", 32'(bus.slot_active), 32'h0);
    checkOutput("doneHoldState", 32'(dut.state_q), 32'(DONE));

    // New level: collect three gems, then restart while slot 3 is in FETCH
    applyStimulus(1'b0, 1'b1, 4'b0000, 1);
    checkOutput("restartScore", 32'(bus.score), 32'h0);
    checkOutput("restartAll", 32'(bus.all_collected), 32'h0);
    for (int s = 0; s < 3; s++) begin
      tick(30);
      step(3);
      checkOutput($sformatf("lvl2Spawn%0d", s), 32'(bus.slot_active[s]), 32'h1);
      applyStimulus(1'b0, 1'b0, 4'(1 << s), 1);
    end
    tick(30);
    step(1);
    checkOutput("midFetchState", 32'(dut.state_q), 32'(FETCH));
    checkOutput("midFetchScore", 32'(bus.score), 32'd3);
    applyStimulus(1'b0, 1'b1, 4'b0000, 1);
    checkOutput("abortScore", 32'(bus.score), 32'h0);
    checkOutput("abortActive", 32'(bus.slot_active), 32'h0);
    checkOutput("abortState", 32'(dut.state_q), 32'(SCAN));
    step(5);
    checkOutput("abortDiscard", 32'(bus.slot_active), 32'h0);
    tick(29);
    step(3);
    checkOutput("abortReload", 32'(bus.slot_active), 32'h0);
    tick(1);
    step(3);
    checkOutput("abortRespawn", 32'(bus.slot_active), 32'b0001);
    checkSlot("abortPos", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gem_spawner.md
Name: gem_spawner

Overview:
- Writer side of the gem interface. Each slot sink reads a gem position and a live flag and reports collection; this block supplies them.
- Owns a fixed pool of on-screen gem slots. It places gems from a level position table, staggering them by frame count.
- It retires collected gems, respawns slots from the next table entry after a delay, and keeps the level score and completion flag.
- It sits between the level/game-state logic and the per-slot gem render/collision sinks.

Parameters:
- SLOTS, 4, number of simultaneous on-screen gem slots.
- TOTAL_GEMS, 8, number of entries in the level position table.
- SPAWN_GAP, 30, frames between successive initial slot spawns.
- RESPAWN_DELAY, 120, frames from collection to refill of that slot.
- TIMER_W, 8, width of each per-slot frame countdown.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame (vsync-derived).
- level_start  in  1  one-cycle pulse; (re)starts the level.
- collect  in  SLOTS  per-slot collision report; a level input, and only the first cycle while the slot is active counts.
- tbl_addr  out  $clog2(TOTAL_GEMS)  position table address; the table is a synchronous ROM with 1-cycle latency.
- tbl_x  in  16  table X (shortint) for the previous cycle's address.
- tbl_y  in  16  table Y (shortint) for the previous cycle's address.
- slot_x  out  SLOTS*16  packed slot X positions.
- slot_y  out  SLOTS*16  packed slot Y positions.
- slot_active  out  SLOTS  slot holds a live gem; sinks blank the slot when 0.
- score  out  $clog2(TOTAL_GEMS+1)  gems collected this level.
- all_collected  out  1  high when score == TOTAL_GEMS.

Behaviour:
- Reset, synchronous, active-high, on Clk: state=IDLE; slot_x/slot_y=0; slot_active=0; score=0; all_collected=0; tbl_addr=0; next_idx=0; all pending=0; all timers=0.
- FSM states: IDLE, SCAN, FETCH, WRITE, DONE.
- IDLE: outputs held. On level_start:
  - every slot: pending=1, timer[i]=SPAWN_GAP*(i+1);
  - slot_active=0, score=0, next_idx=0;
  - go to SCAN.
- level_start in any other state: same initialisation. It takes priority over every other event that cycle.
- Timers: in SCAN/FETCH/WRITE, each frame_tick decrements every pending timer that is >0. Timers never wrap below 0.
- SCAN:
  - Select the lowest-index slot with pending=1, timer=0 and next_idx<TOTAL_GEMS.
  - If found: drive tbl_addr=next_idx and go to FETCH. Otherwise stay.
- FETCH: wait state covering ROM latency; go to WRITE.
- WRITE:
  - latch slot_x/slot_y[sel] from tbl_x/tbl_y; slot_active[sel]=1; pending[sel]=0; next_idx+=1;
  - go to SCAN.
  - Fetch-to-visible latency is 3 cycles after timer expiry is seen in SCAN.
- Collection, evaluated every cycle in SCAN/FETCH/WRITE:
  - A slot counts when collect[i] && slot_active[i].
  - That slot: slot_active=0 next cycle; score += popcount of counted slots (same-cycle multiple collections all count).
  - If next_idx<TOTAL_GEMS: pending=1, timer=RESPAWN_DELAY. Otherwise the slot stays empty.
  - collect on an inactive slot is ignored.
  - collect on the slot being written in WRITE is ignored that cycle.
- Table exhausted: pending slots are never filled. SCAN idles until collections finish.
- score == TOTAL_GEMS: go to DONE with all_collected=1. DONE holds all outputs until level_start or Reset.
- score saturates at TOTAL_GEMS.
- Simultaneous timer expiries are served one per 3-cycle fetch, lowest index first; the others wait with timer=0.

Optional Feature:
- Macro: GEM_SPAWN_JITTER_EN.
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on Reset and level_start) advances every frame_tick. The respawn timer loads RESPAWN_DELAY + LFSR[4:0], i.e. 0..31 extra frames.
- Undefined: the respawn timer loads exactly RESPAWN_DELAY, with no LFSR logic.

Decomposition:
- Package gem_pkg holds:
  - spawn_state_t enum (IDLE, SCAN, FETCH, WRITE, DONE);
  - gem_pos_t packed struct {shortint x; shortint y;};
  - the default SPAWN_GAP/RESPAWN_DELAY constants;
  - the LFSR seed/taps.
- Sub-module gem_slot_timer, one per slot via generate. It holds pending flag + countdown, with inputs load, load_val, frame_tick, clear, and outputs ready (pending && timer==0).

Test Plan:
- Reset, then level_start, then 30 frame_ticks → slot0 active 3 cycles after tick 30 with table[0] (e.g. X=320, Y=440). Slot1 active after tick 60, slot3 after tick 120; next_idx=4.
- All 4 active; pulse collect=4'b0101 for one cycle → slot_active=4'b1010 next cycle, score=2. Slots 0 and 2 refill after 120 ticks, slot0 first (table[4]) then slot2 (table[5]) 3 cycles later.
- collect held high for 10 cycles on active slot1 → score increments by exactly 1.
- Collect all 8 gems → after the 8th, slots stay empty, score=8, all_collected=1 and state DONE. Further collect/frame_tick change nothing.
- level_start mid-FETCH with score=3 → next cycle slot_active=0, score=0, all timers reloaded to SPAWN_GAP*(i+1), and the fetched entry is discarded.
- With GEM_SPAWN_JITTER_EN → respawn interval lies in [120,151] frames and matches the reference LFSR sequence from seed 8'hA5.
